// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall vector bit positions,
// the stall vector patterns, branch flag levels and the redirect FSM encoding.
package pipe_stall_ctrl_pkg;

  localparam int STALL_BIT_PC    = 0;
  localparam int STALL_BIT_IF_ID = 1;
  localparam int STALL_BIT_ID_EX = 2;
  localparam int STALL_BIT_EX_MEM = 3;
  localparam int STALL_BIT_MEM_WB = 4;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  localparam logic BRANCH_ENABLE  = 1'b1;
  localparam logic BRANCH_DISABLE = 1'b0;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Saturating stall-cycle counter plus a stuck-stall watchdog with sticky flag.
module pipe_stall_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             stall_timeout_o
);

  localparam int RUN_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    run_d     = run_q;
    timeout_d = timeout_q;
    if (clr_i) begin
      cnt_d     = '0;
      run_d     = '0;
      timeout_d = 1'b0;
    end else if (stall_i) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      // Run length holds at the limit; the sticky flag carries the event.
      if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      if (run_q >= RUN_LAST) timeout_d = 1'b1;
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      run_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cycles_o  = cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests and owns branch redirection,
// deferring a taken branch while an instruction fetch is still outstanding.
//   state   | meaning
//   IDLE    | no redirect pending; branches from EX redirect immediately
//   BR_WAIT | taken branch latched, waiting for the fetch bus to go ready
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             branch_req_i,
  input  logic [31:0]      branch_addr_i,
  input  logic             clr_stats_i,
  output logic [4:0]       stalled_o,
  output logic             branch_flag_o,
  output logic [31:0]      branch_addr_o,
  output logic             br_pending_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             stall_timeout_o
);

  logic [0:0]  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [4:0]  stall_vec;
  logic        br_accept;
  logic        flag;

  always_comb begin
    stall_vec = STALL_NONE;
    if (!rst) begin
      if (stallreq_mem_i)                     stall_vec = STALL_MEM;
      else if (stallreq_ex_i)                 stall_vec = STALL_EX;
      else if (stallreq_id_i || stallreq_if_i) stall_vec = STALL_ID;
    end
  end

  // A branch can only leave EX when the EX/MEM register is advancing.
  assign br_accept = branch_req_i && !stall_vec[STALL_BIT_EX_MEM];

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    flag     = BRANCH_DISABLE;
    case (state_q)
      ST_IDLE: begin
        if (br_accept) begin
          if (stallreq_if_i) begin
            state_d  = ST_BR_WAIT;
            target_d = branch_addr_i;
          end else begin
            flag = BRANCH_ENABLE;
          end
        end
      end
      ST_BR_WAIT: begin
        if (!stallreq_if_i) begin
          flag    = BRANCH_ENABLE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign stalled_o     = stall_vec;
  assign branch_flag_o = rst ? BRANCH_DISABLE : flag;
  assign br_pending_o  = !rst && (state_q == ST_BR_WAIT);
  assign branch_addr_o = rst ? 32'h0 :
                         (state_q == ST_BR_WAIT) ? target_q : branch_addr_i;

  pipe_stall_ctrl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_vec != STALL_NONE),
    .clr_i          (clr_stats_i),
    .stall_cycles_o (stall_cycles_o),
    .stall_timeout_o(stall_timeout_o)
  );

endmodule
